detect_collision: RTL

- Pipelined two-ball overlap test feeding rectify_p_in_collision.
- Takes a ball-pair's centres and the common radius, computes squared centre distance in full precision and flags overlap against (2*radius)^2.
- Forwards the positions, radius and flags with a valid/ready handshake so the downstream position-rectify stage runs only on colliding pairs.

---
 rtl/billiard_pkg.sv | 16 +
 rtl/pipe_stage_reg.sv | 30 +++
 rtl/detect_collision.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/billiard_pkg.sv
// billiard_pkg: shared widths and the ball-pair record for the billiard collision pipeline.
package billiard_pkg;

    localparam int WIDTH      = 32;
    localparam int FRAC_WIDTH = 30;
    localparam int SQ_WIDTH   = 2*WIDTH+2;

    typedef struct packed {
        logic signed [WIDTH-1:0] x0;
        logic signed [WIDTH-1:0] y0;
        logic signed [WIDTH-1:0] x1;
        logic signed [WIDTH-1:0] y1;
        logic signed [WIDTH-1:0] radius;
    } pair_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: W-bit data + valid pipeline register with enable and async active-low reset.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/detect_collision.sv
// detect_collision: 3-stage exact two-ball overlap test with a global-stall valid/ready pipeline.
// Define COLLIDE_STATS_EN to add a saturating collide_count output.
module detect_collision
    import billiard_pkg::*;
#(
    parameter int WIDTH      = billiard_pkg::WIDTH,
    parameter int FRAC_WIDTH = billiard_pkg::FRAC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   x0,
    input  logic signed [WIDTH-1:0]   y0,
    input  logic signed [WIDTH-1:0]   x1,
    input  logic signed [WIDTH-1:0]   y1,
    input  logic signed [WIDTH-1:0]   radius,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_x0,
    output logic signed [WIDTH-1:0]   out_y0,
    output logic signed [WIDTH-1:0]   out_x1,
    output logic signed [WIDTH-1:0]   out_y1,
    output logic signed [WIDTH-1:0]   out_radius,
`ifdef COLLIDE_STATS_EN
    output logic [15:0]               collide_count,
`endif
    output logic                      collide,
    output logic                      degenerate,
    output logic [2*WIDTH+1:0]        dist_sq
);

    localparam int SQW = 2*WIDTH+2;

    // The Q format must leave at least one integer (sign) bit.
    if (FRAC_WIDTH >= WIDTH || FRAC_WIDTH < 0) begin : g_bad_fmt
        $error("detect_collision: FRAC_WIDTH must be in [0, WIDTH-1]");
    end

    typedef struct packed {
        logic signed [WIDTH-1:0] x0;
        logic signed [WIDTH-1:0] y0;
        logic signed [WIDTH-1:0] x1;
        logic signed [WIDTH-1:0] y1;
        logic signed [WIDTH-1:0] radius;
    } pair_w_t;

    typedef struct packed {
        pair_w_t               p;
        logic signed [WIDTH:0] dx;
        logic signed [WIDTH:0] dy;
        logic signed [WIDTH:0] r2;
    } s1_t;

    typedef struct packed {
        pair_w_t             p;
        logic signed [SQW-1:0] dx2;
        logic signed [SQW-1:0] dy2;
        logic signed [SQW-1:0] r2sq;
    } s2_t;

    typedef struct packed {
        pair_w_t      p;
        logic [SQW-1:0] dist_sq;
        logic         collide;
        logic         degenerate;
    } s3_t;

    logic    w_adv;
    logic    w_v1, w_v2, w_v3;
    s1_t     w_s1_d, w_s1_q;
    s2_t     w_s2_d, w_s2_q;
    s3_t     w_s3_d, w_s3_q;
    logic [SQW-1:0] w_sum;

    // One global enable: every stage moves together or the whole pipe holds.
    assign w_adv    = !w_v3 || out_ready;
    assign in_ready = w_adv;

    // Sign-extend by one bit so differences and 2*radius never overflow.
    always_comb begin
        w_s1_d.p  = {x0, y0, x1, y1, radius};
        w_s1_d.dx = {x0[WIDTH-1], x0} - {x1[WIDTH-1], x1};
        w_s1_d.dy = {y0[WIDTH-1], y0} - {y1[WIDTH-1], y1};
        w_s1_d.r2 = {radius, 1'b0};
    end

    always_comb begin
        w_s2_d.p    = w_s1_q.p;
        w_s2_d.dx2  = SQW'(w_s1_q.dx) * SQW'(w_s1_q.dx);
        w_s2_d.dy2  = SQW'(w_s1_q.dy) * SQW'(w_s1_q.dy);
        w_s2_d.r2sq = SQW'(w_s1_q.r2) * SQW'(w_s1_q.r2);
    end

    // Squares are non-negative and below 2^(SQW-1), so unsigned compare is exact.
    always_comb begin
        w_sum             = $unsigned(w_s2_q.dx2) + $unsigned(w_s2_q.dy2);
        w_s3_d.p          = w_s2_q.p;
        w_s3_d.dist_sq    = w_sum;
        w_s3_d.degenerate = (w_sum == '0);
        w_s3_d.collide    = (w_sum < $unsigned(w_s2_q.r2sq)) || (w_sum == '0);
    end

    pipe_stage_reg #(.W($bits(s1_t))) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_valid (in_valid),
        .i_data  (w_s1_d),
        .o_valid (w_v1),
        .o_data  (w_s1_q)
    );

    pipe_stage_reg #(.W($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_valid (w_v1),
        .i_data  (w_s2_d),
        .o_valid (w_v2),
        .o_data  (w_s2_q)
    );

    pipe_stage_reg #(.W($bits(s3_t))) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_valid (w_v2),
        .i_data  (w_s3_d),
        .o_valid (w_v3),
        .o_data  (w_s3_q)
    );

    assign out_valid  = w_v3;
    assign out_x0     = w_s3_q.p.x0;
    assign out_y0     = w_s3_q.p.y0;
    assign out_x1     = w_s3_q.p.x1;
    assign out_y1     = w_s3_q.p.y1;
    assign out_radius = w_s3_q.p.radius;
    assign dist_sq    = w_s3_q.dist_sq;
    assign collide    = w_s3_q.collide;
    assign degenerate = w_s3_q.degenerate;

`ifdef COLLIDE_STATS_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (w_v3 && out_ready && w_s3_q.collide && r_count != 16'hFFFF)
            r_count <= r_count + 16'd1;
    end

    assign collide_count = r_count;
`endif

endmodule
